// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and default widths for the pipeline stage register.
package pipe_pkg;
  localparam int PIPE_DATA_W = 96;
  localparam int PIPE_CTRL_W = 6;
  localparam int PIPE_CNT_W  = 16;

  // Encoding equals the entry count so occupancy can be read directly.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_e;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with increment enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                     cnt_o <= '0;
    else if (inc_i && cnt_o != '1)  cnt_o <= cnt_o + W'(1);
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: one head entry plus optional skid entry, with flush
// and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int CTRL_W = PIPE_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              flush_i,
  output logic [1:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);
  stage_state_e      state_q, state_d;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl;
  logic [DATA_W-1:0] head_data, skid_data;
  logic              acc, ret;

  assign acc = in_valid_i & in_ready_o;
  assign ret = out_valid_o & out_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) state_d = EMPTY;
    else begin
      case (state_q)
        EMPTY:   if (acc) state_d = ONE;
        ONE: begin
          if (ret && !acc)                    state_d = EMPTY;
          else if (acc && !ret && SKID != 0)  state_d = TWO;
        end
        TWO:     if (ret) state_d = ONE;
        default: state_d = EMPTY;
      endcase
    end
  end

  // With SKID the ready is a pure function of the state flop, breaking the
  // out_ready_i -> in_ready_o timing path.
  always_comb begin
    out_valid_o = (state_q != EMPTY);
    occ_o       = state_q;
    if (SKID != 0) in_ready_o = (state_q != TWO);
    else           in_ready_o = ~out_valid_o | out_ready_i;
    out_ctrl_o  = out_valid_o ? head_ctrl : '0;
    out_data_o  = head_data;
  end

  // Payload survives flush; only control is cleared so bubbles become NOPs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      head_ctrl <= '0;
      head_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush_i) begin
      head_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      case (state_q)
        EMPTY: if (acc) begin
          head_ctrl <= in_ctrl_i;
          head_data <= in_data_i;
        end
        ONE: begin
          if (acc && ret) begin
            head_ctrl <= in_ctrl_i;
            head_data <= in_data_i;
          end else if (acc && SKID != 0) begin
            skid_ctrl <= in_ctrl_i;
            skid_data <= in_data_i;
          end
        end
        TWO: if (ret) begin
          head_ctrl <= skid_ctrl;
          head_data <= skid_data;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (out_valid_o & ~out_ready_i),
    .cnt_o (stall_cnt_o)
  );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: queue-based reference model driving three instances
// (skid, skid with 4-bit counter, no-skid) from shared inputs.
module tb_pipe_stage_reg;
  localparam int DW = 96;
  localparam int CW = 6;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, out_ready = 1'b0, flush = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;

  logic a_ir, a_ov, b_ir, b_ov, z_ir, z_ov;
  logic [CW-1:0] a_oc, b_oc, z_oc;
  logic [DW-1:0] a_od, b_od, z_od;
  logic [1:0]    a_occ, b_occ, z_occ;
  logic [15:0]   a_st, z_st;
  logic [3:0]    b_st;

  ent_t q1[$], q0[$];
  int   st1, st0;
  int   checks = 0, failures = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(a_ir),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(a_ov), .out_ready_i(out_ready),
    .out_ctrl_o(a_oc), .out_data_o(a_od), .flush_i(flush), .occ_o(a_occ), .stall_cnt_o(a_st));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_c4 (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(b_ir),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(b_ov), .out_ready_i(out_ready),
    .out_ctrl_o(b_oc), .out_data_o(b_od), .flush_i(flush), .occ_o(b_occ), .stall_cnt_o(b_st));

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_s0 (
    .clk_i(clk), .rst_i(rst_n), .in_valid_i(in_valid), .in_ready_o(z_ir),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(z_ov), .out_ready_i(out_ready),
    .out_ctrl_o(z_oc), .out_data_o(z_od), .flush_i(flush), .occ_o(z_occ), .stall_cnt_o(z_st));

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom};
  endfunction

  // Advance one clock, updating the model from the inputs the DUT samples.
  task automatic tick();
    bit v1, v0, r1, r0;
    v1 = q1.size() != 0;
    v0 = q0.size() != 0;
    r1 = q1.size() < 2;
    r0 = !v0 || out_ready;
    if (v1 && !out_ready) st1++;
    if (v0 && !out_ready) st0++;
    if (flush) begin
      q1.delete();
      q0.delete();
    end else begin
      if (v1 && out_ready) void'(q1.pop_front());
      if (in_valid && r1)  q1.push_back({in_ctrl, in_data});
      if (v0 && out_ready) void'(q0.pop_front());
      if (in_valid && r0)  q0.push_back({in_ctrl, in_data});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    q1.delete();
    q0.delete();
    st1 = 0;
    st0 = 0;
    #2;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1;
    checks++;
    if (a_occ !== 2'd0 || a_ov !== 1'b0 || a_oc !== '0 || a_od !== '0 || a_st !== '0 || a_ir !== 1'b1) begin
      failures++;
      $display("FAIL reset_state occ=%0d v=%b ctrl=%h data=%h st=%0d rdy=%b, required 0 0 0 0 0 1",
               a_occ, a_ov, a_oc, a_od, a_st, a_ir);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_ir !== 1'b1 || z_ir !== 1'b1 || b_st !== 4'd0) begin
      failures++;
      $display("FAIL reset_release rdy=%b s0_rdy=%b c4_st=%0d, required 1 1 0", a_ir, z_ir, b_st);
    end
  endtask

  task automatic test_first();
    in_valid = 1'b1; in_ctrl = 6'h2A; in_data = 96'h5; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_oc !== 6'h2A || a_od !== 96'h5 || a_occ !== 2'd1) begin
      failures++;
      $display("FAIL first_entry v=%b ctrl=%h data=%h occ=%0d, required 1 2a 5 1", a_ov, a_oc, a_od, a_occ);
    end
  endtask

  task automatic test_skid();
    logic [DW-1:0] da, db;
    da = rnd_data(); db = rnd_data();
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 6'h11; in_data = da;
    tick();
    in_ctrl = 6'h22; in_data = db;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_occ !== 2'd2 || a_ir !== 1'b0 || a_od !== da || a_oc !== 6'h11) begin
      failures++;
      $display("FAIL skid_full occ=%0d rdy=%b ctrl=%h, required 2 0 11", a_occ, a_ir, a_oc);
    end
    checks++;
    if (z_occ !== 2'd1 || z_od !== da) begin
      failures++;
      $display("FAIL noskid_single occ=%0d data=%h, required 1 %h", z_occ, z_od, da);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (a_ov !== 1'b1 || a_od !== db || a_oc !== 6'h22 || a_occ !== 2'd1 || a_ir !== 1'b1) begin
      failures++;
      $display("FAIL skid_drain_b v=%b ctrl=%h occ=%0d rdy=%b, required 1 22 1 1", a_ov, a_oc, a_occ, a_ir);
    end
    tick();
    checks++;
    if (a_ov !== 1'b0 || a_oc !== '0 || a_occ !== 2'd0) begin
      failures++;
      $display("FAIL skid_drained v=%b ctrl=%h occ=%0d, required 0 0 0", a_ov, a_oc, a_occ);
    end
  endtask

  task automatic test_stream();
    ent_t sent;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_valid = 1'b1; in_ctrl = CW'($urandom); in_data = rnd_data();
      sent = {in_ctrl, in_data};
      tick();
      checks++;
      if (a_ov !== 1'b1 || {a_oc, a_od} !== sent || a_occ !== 2'd1 || {z_oc, z_od} !== sent) begin
        failures++;
        $display("FAIL stream_%0d v=%b got=%h s0=%h, required %h", i, a_ov, {a_oc, a_od}, {z_oc, z_od}, sent);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (a_ov !== 1'b0 || a_st !== 16'd0 || z_st !== 16'd0) begin
      failures++;
      $display("FAIL stream_end v=%b st=%0d s0_st=%0d, required 0 0 0", a_ov, a_st, z_st);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_ctrl = 6'h3F; in_data = rnd_data();
      tick();
    end
    checks++;
    if (a_occ !== 2'd2) begin
      failures++;
      $display("FAIL flush_fill occ=%0d, required 2", a_occ);
    end
    flush = 1'b1; in_ctrl = 6'h15; in_data = rnd_data();
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (a_ov !== 1'b0 || a_oc !== '0 || a_occ !== 2'd0 || z_occ !== 2'd0 || z_oc !== '0) begin
      failures++;
      $display("FAIL flush v=%b ctrl=%h occ=%0d s0_occ=%0d, required 0 0 0 0", a_ov, a_oc, a_occ, z_occ);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (a_ov !== 1'b0 || a_occ !== 2'd0 || z_ov !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_leak v=%b occ=%0d s0_v=%b, required 0 0 0", a_ov, a_occ, z_ov);
    end
  endtask

  task automatic test_sat();
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 6'h01; in_data = rnd_data();
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (b_st !== 4'd15 || a_st !== 16'd20) begin
      failures++;
      $display("FAIL stall_sat c4=%0d c16=%0d, required 15 20", b_st, a_st);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 6'h07; in_data = rnd_data();
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_occ !== 2'd2) begin
      failures++;
      $display("FAIL async_fill occ=%0d, required 2", a_occ);
    end
    #2;
    rst_n = 1'b0;
    q1.delete(); q0.delete(); st1 = 0; st0 = 0;
    #1;
    checks++;
    if (a_occ !== 2'd0 || a_ov !== 1'b0 || a_oc !== '0 || a_od !== '0 || a_st !== '0 || b_st !== '0 || a_ir !== 1'b1) begin
      failures++;
      $display("FAIL async_reset occ=%0d v=%b ctrl=%h st=%0d c4=%0d rdy=%b, required 0 0 0 0 0 1",
               a_occ, a_ov, a_oc, a_st, b_st, a_ir);
    end
    rst_n = 1'b1;
    in_valid = 1'b1; in_ctrl = 6'h19; in_data = 96'hABC; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (a_ov !== 1'b1 || a_oc !== 6'h19 || a_od !== 96'hABC || a_occ !== 2'd1) begin
      failures++;
      $display("FAIL post_reset_accept v=%b ctrl=%h occ=%0d, required 1 19 1", a_ov, a_oc, a_occ);
    end
  endtask

  task automatic test_random();
    ent_t e1, e0;
    int   x1, x0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = (i % 64 < 40) ? (($urandom % 3) != 0) : (($urandom % 5) == 0);
      flush     = ($urandom % 16) == 0;
      in_ctrl   = CW'($urandom);
      in_data   = rnd_data();
      #1;
      checks++;
      if (a_ir !== (q1.size() < 2) || z_ir !== (q0.size() == 0 || out_ready)) begin
        failures++;
        $display("FAIL rand_ready cyc=%0d rdy=%b s0_rdy=%b occ=%0d/%0d", i, a_ir, z_ir, q1.size(), q0.size());
      end
      tick();
      e1 = (q1.size() != 0) ? q1[0] : '0;
      e0 = (q0.size() != 0) ? q0[0] : '0;
      x1 = (st1 > 65535) ? 65535 : st1;
      x0 = (st0 > 65535) ? 65535 : st0;
      checks++;
      if (a_ov !== (q1.size() != 0) || a_occ !== 2'(q1.size()) || a_oc !== e1[CW+DW-1:DW] ||
          (a_ov && a_od !== e1[DW-1:0]) || a_st !== 16'(x1) || b_st !== 4'((st1 > 15) ? 15 : st1)) begin
        failures++;
        $display("FAIL rand_skid cyc=%0d occ=%0d ctrl=%h data=%h st=%0d c4=%0d, required %0d %h %h %0d",
                 i, a_occ, a_oc, a_od, a_st, b_st, q1.size(), e1[CW+DW-1:DW], e1[DW-1:0], x1);
      end
      checks++;
      if (z_ov !== (q0.size() != 0) || z_occ !== 2'(q0.size()) || z_oc !== e0[CW+DW-1:DW] ||
          (z_ov && z_od !== e0[DW-1:0]) || z_st !== 16'(x0)) begin
        failures++;
        $display("FAIL rand_noskid cyc=%0d occ=%0d ctrl=%h data=%h st=%0d, required %0d %h %h %0d",
                 i, z_occ, z_oc, z_od, z_st, q0.size(), e0[CW+DW-1:DW], e0[DW-1:0], x0);
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first();
    test_skid();
    test_stream();
    test_flush();
    test_sat();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
